storage_ctl: RTL and testbench

//  Loads audio from the SD-card controller into external 16-bit RAM, then serves playback reads.

---
 rtl/storage_ctl.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_storage_ctl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/storage_ctl.sv
// rtl/storage_ctl.sv - SD-card audio loader into 16-bit RAM with playback read arbitration
// storage_ctl: pairs bytes from 512-byte SD sector reads into little-endian words,
//   queues them and writes them to RAM from word 0 upward, announces the slot
//   start addresses on completion, and serves playback reads in between.
// Ports:
//   clk, reset (async, active-low)
//   SD side:        spi_clk, load, sd_ready, sd_address, sd_rd, sd_dout,
//                   sd_byte_available, sd_wr, sd_din, ready_for_next_byte
//   samplectl side: update, start_a
//   playback side:  play, playback_a, audio_out
//   RAM side:       ram_a, ram_dq_i, ram_dq_o, ram_cen, ram_oen, ram_wen

// storage_ctl_sd: SD sector-read sequencer and byte-to-word packer.
// Ports: clk, reset; spi_clk, load, sd_ready, sd_dout, sd_byte_available in;
//   sd_address, sd_rd, update, start_a, push, push_data ({addr, word}) out.
module storage_ctl_sd #(
  parameter logic [31:0] LOAD_BYTES = 32'd1048576,
  parameter int          NUM_SLOTS  = 4,
  parameter logic [26:0] SLOT_WORDS = 27'd131072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_clk,
  input  logic        load,
  input  logic        sd_ready,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  output logic [31:0] sd_address,
  output logic        sd_rd,
  output logic        update,
  output logic [26:0] start_a,
  output logic        push,
  output logic [42:0] push_data
);
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SD_START    = 3'd1,
    SD_LISTEN   = 3'd2,
    SD_REC      = 3'd3,
    SD_FINISH_1 = 3'd4,
    SD_FINISH_2 = 3'd5,
    SD_DONE     = 3'd6
  } sd_state_e;

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  sd_state_e     state, state_d;
  logic          spi_prev_q;
  logic [31:0]   sd_address_q, sd_address_d;
  logic          sd_rd_q, sd_rd_d;
  logic [9:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    low_byte_q, low_byte_d;
  logic [26:0]   word_ptr_q, word_ptr_d;
  logic          update_q, update_d;
  logic [26:0]   start_a_q, start_a_d;
  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic          push_q, push_d;
  logic [42:0]   push_data_q, push_data_d;
  logic          spi_edge;
  logic [31:0]   next_addr;

  // spi_clk is slow relative to clk; only a 0->1 change between samples counts.
  assign spi_edge  = spi_clk && !spi_prev_q;
  assign next_addr = sd_address_q + 32'd512;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      spi_prev_q   <= 1'b0;
      sd_address_q <= '0;
      sd_rd_q      <= 1'b0;
      byte_cnt_q   <= '0;
      low_byte_q   <= '0;
      word_ptr_q   <= '0;
      update_q     <= 1'b0;
      start_a_q    <= '0;
      slot_cnt_q   <= '0;
      push_q       <= 1'b0;
      push_data_q  <= '0;
    end else begin
      state        <= state_d;
      spi_prev_q   <= spi_clk;
      sd_address_q <= sd_address_d;
      sd_rd_q      <= sd_rd_d;
      byte_cnt_q   <= byte_cnt_d;
      low_byte_q   <= low_byte_d;
      word_ptr_q   <= word_ptr_d;
      update_q     <= update_d;
      start_a_q    <= start_a_d;
      slot_cnt_q   <= slot_cnt_d;
      push_q       <= push_d;
      push_data_q  <= push_data_d;
    end
  end

  always_comb begin
    state_d      = state;
    sd_address_d = sd_address_q;
    sd_rd_d      = sd_rd_q;
    byte_cnt_d   = byte_cnt_q;
    low_byte_d   = low_byte_q;
    word_ptr_d   = word_ptr_q;
    update_d     = update_q;
    start_a_d    = start_a_q;
    slot_cnt_d   = slot_cnt_q;
    push_d       = 1'b0;
    push_data_d  = push_data_q;
    case (state)
      IDLE, SD_DONE: begin
        if (load) begin
          state_d      = SD_START;
          sd_address_d = '0;
          byte_cnt_d   = '0;
          word_ptr_d   = '0;
          sd_rd_d      = 1'b0;
          update_d     = 1'b0;
        end else if (update_q) begin
          // Step through slot starts, one per clk, then drop update.
          if (slot_cnt_q == SW'(NUM_SLOTS - 1)) begin
            update_d = 1'b0;
          end else begin
            slot_cnt_d = slot_cnt_q + SW'(1);
            start_a_d  = start_a_q + SLOT_WORDS;
          end
        end
      end
      SD_START: begin
        if (spi_edge && sd_ready) begin
          sd_rd_d = 1'b1;
          state_d = SD_REC;
        end
      end
      SD_REC: begin
        if (!sd_ready) sd_rd_d = 1'b0;
        if (spi_edge && sd_byte_available) begin
          byte_cnt_d = byte_cnt_q + 10'd1;
          // Sector length is even, so the per-sector count also gives byte parity.
          if (byte_cnt_q[0]) begin
            push_d      = 1'b1;
            push_data_d = {word_ptr_q, sd_dout, low_byte_q};
            word_ptr_d  = word_ptr_q + 27'd1;
          end else begin
            low_byte_d = sd_dout;
          end
          state_d = SD_LISTEN;
        end
      end
      SD_LISTEN: begin
        if (!sd_ready) sd_rd_d = 1'b0;
        if (spi_edge && !sd_byte_available) begin
          state_d = (byte_cnt_q == 10'd512) ? SD_FINISH_1 : SD_REC;
        end
      end
      SD_FINISH_1: begin
        sd_rd_d = 1'b0;
        if (spi_edge) state_d = SD_FINISH_2;
      end
      SD_FINISH_2: begin
        sd_address_d = next_addr;
        byte_cnt_d   = '0;
        if (next_addr >= LOAD_BYTES) begin
          state_d    = SD_DONE;
          update_d   = 1'b1;
          start_a_d  = '0;
          slot_cnt_d = '0;
        end else begin
          state_d = SD_START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sd_address = sd_address_q;
  assign sd_rd      = sd_rd_q;
  assign update     = update_q;
  assign start_a    = start_a_q;
  assign push       = push_q;
  assign push_data  = push_data_q;
endmodule

// storage_ctl_fifo: RAM write-request queue; pushes into a full queue are dropped.
// Ports: clk, reset; push, push_data, pop in; pop_data (head), empty, full, count out.
module storage_ctl_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 43,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + CW'(1);
    if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
endmodule

// storage_ctl_arbiter: single-port RAM sequencer for playback reads and queued writes.
// Ports: clk, reset; play, playback_a, fifo_empty, fifo_count, fifo_head, ram_dq_o in;
//   fifo_pop, ram_a, ram_dq_i, ram_cen, ram_oen, ram_wen, audio_out out.
module storage_ctl_arbiter #(
  parameter int DEPTH     = 16,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          play,
  input  logic [26:0]   playback_a,
  input  logic          fifo_empty,
  input  logic [CW-1:0] fifo_count,
  input  logic [42:0]   fifo_head,
  input  logic [15:0]   ram_dq_o,
  output logic          fifo_pop,
  output logic [26:0]   ram_a,
  output logic [15:0]   ram_dq_i,
  output logic          ram_cen,
  output logic          ram_oen,
  output logic          ram_wen,
  output logic [15:0]   audio_out
);
  localparam int MAXC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int NW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {OP_IDLE, OP_READ, OP_WRITE} op_e;

  op_e          op_q, op_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [26:0]  ram_a_q, ram_a_d;
  logic [15:0]  ram_dq_i_q, ram_dq_i_d;
  logic         cen_q, cen_d, oen_q, oen_d, wen_q, wen_d;
  logic [15:0]  audio_q, audio_d;
  logic         write_urgent;

  // A nearly full queue takes the RAM ahead of playback so no word is lost.
  assign write_urgent = !fifo_empty && (fifo_count >= CW'(DEPTH - 2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= OP_IDLE;
      cnt_q      <= '0;
      ram_a_q    <= '0;
      ram_dq_i_q <= '0;
      cen_q      <= 1'b1;
      oen_q      <= 1'b1;
      wen_q      <= 1'b1;
      audio_q    <= '0;
    end else begin
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      ram_a_q    <= ram_a_d;
      ram_dq_i_q <= ram_dq_i_d;
      cen_q      <= cen_d;
      oen_q      <= oen_d;
      wen_q      <= wen_d;
      audio_q    <= audio_d;
    end
  end

  always_comb begin
    op_d       = op_q;
    cnt_d      = cnt_q;
    ram_a_d    = ram_a_q;
    ram_dq_i_d = ram_dq_i_q;
    cen_d      = cen_q;
    oen_d      = oen_q;
    wen_d      = wen_q;
    audio_d    = audio_q;
    fifo_pop   = 1'b0;
    case (op_q)
      OP_IDLE: begin
        if (play && !write_urgent) begin
          op_d    = OP_READ;
          cnt_d   = '0;
          ram_a_d = playback_a;
          cen_d   = 1'b0;
          oen_d   = 1'b0;
          wen_d   = 1'b1;
        end else if (!fifo_empty) begin
          op_d       = OP_WRITE;
          cnt_d      = '0;
          fifo_pop   = 1'b1;
          ram_a_d    = fifo_head[42:16];
          ram_dq_i_d = fifo_head[15:0];
          cen_d      = 1'b0;
          oen_d      = 1'b1;
          wen_d      = 1'b0;
        end
      end
      OP_READ: begin
        if (cnt_q == NW'(RD_CYCLES - 1)) begin
          audio_d = ram_dq_o;
          op_d    = OP_IDLE;
          cen_d   = 1'b1;
          oen_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + NW'(1);
        end
      end
      OP_WRITE: begin
        if (cnt_q == NW'(WR_CYCLES - 1)) begin
          op_d  = OP_IDLE;
          cen_d = 1'b1;
          wen_d = 1'b1;
        end else begin
          cnt_d = cnt_q + NW'(1);
        end
      end
      default: begin
        op_d  = OP_IDLE;
        cen_d = 1'b1;
        oen_d = 1'b1;
        wen_d = 1'b1;
      end
    endcase
  end

  assign ram_a     = ram_a_q;
  assign ram_dq_i  = ram_dq_i_q;
  assign ram_cen   = cen_q;
  assign ram_oen   = oen_q;
  assign ram_wen   = wen_q;
  assign audio_out = audio_q;
endmodule

module storage_ctl #(
  parameter logic [31:0] LOAD_BYTES = 32'd1048576,
  parameter int          NUM_SLOTS  = 4,
  parameter logic [26:0] SLOT_WORDS = 27'd131072,
  parameter int          FIFO_DEPTH = 16,
  parameter int          WR_CYCLES  = 2,
  parameter int          RD_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_clk,
  input  logic        load,
  input  logic        sd_ready,
  output logic [31:0] sd_address,
  output logic        sd_rd,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  output logic        sd_wr,
  output logic [7:0]  sd_din,
  input  logic        ready_for_next_byte,
  output logic        update,
  output logic [26:0] start_a,
  input  logic        play,
  input  logic [26:0] playback_a,
  output logic [26:0] ram_a,
  output logic [15:0] ram_dq_i,
  input  logic [15:0] ram_dq_o,
  output logic        ram_cen,
  output logic        ram_oen,
  output logic        ram_wen,
  output logic [15:0] audio_out
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          push, pop, fifo_empty, fifo_full;
  logic [42:0]   push_data, fifo_head;
  logic [CW-1:0] fifo_count;
  logic          unused_ok;

  assign sd_wr     = 1'b0;
  assign sd_din    = 8'd0;
  assign unused_ok = ready_for_next_byte | fifo_full;

  storage_ctl_sd #(
    .LOAD_BYTES (LOAD_BYTES),
    .NUM_SLOTS  (NUM_SLOTS),
    .SLOT_WORDS (SLOT_WORDS)
  ) sd_i (
    .clk               (clk),
    .reset             (reset),
    .spi_clk           (spi_clk),
    .load              (load),
    .sd_ready          (sd_ready),
    .sd_dout           (sd_dout),
    .sd_byte_available (sd_byte_available),
    .sd_address        (sd_address),
    .sd_rd             (sd_rd),
    .update            (update),
    .start_a           (start_a),
    .push              (push),
    .push_data         (push_data)
  );

  storage_ctl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (43),
    .CW    (CW)
  ) fifo_req (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  storage_ctl_arbiter #(
    .DEPTH     (FIFO_DEPTH),
    .WR_CYCLES (WR_CYCLES),
    .RD_CYCLES (RD_CYCLES),
    .CW        (CW)
  ) arbiter (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .playback_a (playback_a),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .fifo_head  (fifo_head),
    .ram_dq_o   (ram_dq_o),
    .fifo_pop   (pop),
    .ram_a      (ram_a),
    .ram_dq_i   (ram_dq_i),
    .ram_cen    (ram_cen),
    .ram_oen    (ram_oen),
    .ram_wen    (ram_wen),
    .audio_out  (audio_out)
  );
endmodule

// File: tb/tb_storage_ctl.sv
// tb/tb_storage_ctl.sv - self-checking bench for storage_ctl
module tb_storage_ctl;
  logic        clk = 1'b0;
  logic        reset, spi_clk, load, sd_ready, sd_byte_available, ready_for_next_byte, play;
  logic [7:0]  sd_dout;
  logic [26:0] playback_a;
  logic [15:0] ram_dq_o;
  logic [31:0] sd_address;
  logic        sd_rd, sd_wr, update, ram_cen, ram_oen, ram_wen;
  logic [7:0]  sd_din;
  logic [26:0] start_a, ram_a;
  logic [15:0] ram_dq_i, audio_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  storage_ctl #(
    .LOAD_BYTES (32'd1024),
    .NUM_SLOTS  (4),
    .SLOT_WORDS (27'd131072),
    .FIFO_DEPTH (16),
    .WR_CYCLES  (2),
    .RD_CYCLES  (2)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .spi_clk             (spi_clk),
    .load                (load),
    .sd_ready            (sd_ready),
    .sd_address          (sd_address),
    .sd_rd               (sd_rd),
    .sd_dout             (sd_dout),
    .sd_byte_available   (sd_byte_available),
    .sd_wr               (sd_wr),
    .sd_din              (sd_din),
    .ready_for_next_byte (ready_for_next_byte),
    .update              (update),
    .start_a             (start_a),
    .play                (play),
    .playback_a          (playback_a),
    .ram_a               (ram_a),
    .ram_dq_i            (ram_dq_i),
    .ram_dq_o            (ram_dq_o),
    .ram_cen             (ram_cen),
    .ram_oen             (ram_oen),
    .ram_wen             (ram_wen),
    .audio_out           (audio_out)
  );

  // RAM-side observer: logs each write once with its length, and each update beat.
  logic [42:0] wr_log[$];
  int          wr_len[$];
  logic [26:0] upd_log[$];
  int          wen_run = 0;

  always @(negedge clk) begin
    if (!ram_cen && !ram_wen) begin
      if (wen_run == 0) wr_log.push_back({ram_a, ram_dq_i});
      wen_run++;
    end else if (wen_run != 0) begin
      wr_len.push_back(wen_run);
      wen_run = 0;
    end
    if (update) upd_log.push_back(start_a);
  end

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] exp;
  } pair_t;

  typedef struct {
    logic [26:0] addr;
    logic [15:0] data;
    logic [15:0] exp_audio;
  } rd_vec_t;

  pair_t       pairs[4];
  rd_vec_t     rds[3];
  logic [42:0] exp_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic spi_tick();
    @(negedge clk) spi_clk = 1'b1;
    repeat (2) @(negedge clk);
    spi_clk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    sd_dout = b;
    sd_byte_available = 1'b1;
    spi_tick();
    sd_byte_available = 1'b0;
    spi_tick();
  endtask

  function automatic logic [7:0] byte_pat(input int s, input int i);
    return 8'((i * 37 + s * 11 + 3) & 255);
  endfunction

  // Feeds all 512 bytes of sector s and records the expected RAM writes.
  task automatic feed_sector(input int s);
    logic [7:0]  lo, hi;
    logic [15:0] w;
    for (int i = 0; i < 512; i += 2) begin
      if (s == 0 && i < 8) begin
        lo = pairs[i / 2].lo;
        hi = pairs[i / 2].hi;
        w  = pairs[i / 2].exp;
      end else begin
        lo = byte_pat(s, i);
        hi = byte_pat(s, i + 1);
        w  = {hi, lo};
      end
      send_byte(lo);
      send_byte(hi);
      exp_log.push_back({27'(s * 256 + i / 2), w});
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!dut.fifo_req.empty && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(name, 64'(dut.fifo_req.empty), 64'd1);
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n;
    int bad;
    logic [15:0] prev_audio;

    pairs[0] = '{lo: 8'h34, hi: 8'h12, exp: 16'h1234};
    pairs[1] = '{lo: 8'hCD, hi: 8'hAB, exp: 16'hABCD};
    pairs[2] = '{lo: 8'h00, hi: 8'hFF, exp: 16'hFF00};
    pairs[3] = '{lo: 8'hFF, hi: 8'h00, exp: 16'h00FF};
    rds[0] = '{addr: 27'd5,         data: 16'hBEEF, exp_audio: 16'hBEEF};
    rds[1] = '{addr: 27'h7FF_FFFF,  data: 16'h0001, exp_audio: 16'h0001};
    rds[2] = '{addr: 27'd0,         data: 16'h8000, exp_audio: 16'h8000};

    reset = 1'b0;
    spi_clk = 1'b0;
    load = 1'b0;
    sd_ready = 1'b0;
    sd_byte_available = 1'b0;
    ready_for_next_byte = 1'b0;
    play = 1'b0;
    sd_dout = 8'd0;
    playback_a = 27'd0;
    ram_dq_o = 16'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_state", 64'(dut.sd_i.state), 64'd0);
    check("reset_strobes", 64'({ram_cen, ram_oen, ram_wen}), 64'b111);
    check("reset_sd", 64'({sd_address, sd_rd, sd_wr, sd_din}), 64'd0);
    check("reset_outs", 64'({update, start_a, audio_out}), 64'd0);
    check("reset_ram", 64'({ram_a, ram_dq_i}), 64'd0);
    check("reset_fifo_empty", 64'(dut.fifo_req.empty), 64'd1);
    reset = 1'b1;

    // Load pulse -> SD_START; no read request until sd_ready
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
    for (n = 0; n < 12 && dut.sd_i.state != 3'd1; n++) @(negedge clk);
    check("load_to_start", 64'(dut.sd_i.state), 64'd1);
    spi_tick();
    check("start_waits_state", 64'(dut.sd_i.state), 64'd1);
    check("start_waits_rd", 64'(sd_rd), 64'd0);

    // sd_ready on an spi edge -> sd_rd, SD_REC; sd_rd drops with sd_ready
    sd_ready = 1'b1;
    @(negedge clk) spi_clk = 1'b1;
    @(negedge clk);
    check("rd_asserted", 64'(sd_rd), 64'd1);
    check("rec_state", 64'(dut.sd_i.state), 64'd3);
    sd_ready = 1'b0;
    spi_clk = 1'b0;
    @(negedge clk);
    check("rd_dropped", 64'(sd_rd), 64'd0);
    @(negedge clk);

    // Sector 0
    feed_sector(0);
    check("finish1_state", 64'(dut.sd_i.state), 64'd4);
    spi_tick();
    check("sector0_next_start", 64'(dut.sd_i.state), 64'd1);
    check("sector0_address", 64'(sd_address), 64'd512);
    wait_drain("sector0_drain");
    check("sector0_writes", 64'(wr_log.size()), 64'd256);

    // Sector 1 -> SD_DONE and slot announcement
    sd_ready = 1'b1;
    spi_tick();
    sd_ready = 1'b0;
    feed_sector(1);
    spi_tick();
    repeat (10) @(negedge clk);
    check("done_state", 64'(dut.sd_i.state), 64'd6);
    check("done_address", 64'(sd_address), 64'd1024);
    check("update_low_after", 64'(update), 64'd0);
    check("update_beats", 64'(upd_log.size()), 64'd4);
    if (upd_log.size() == 4) begin
      check("start_a_0", 64'(upd_log[0]), 64'd0);
      check("start_a_1", 64'(upd_log[1]), 64'd131072);
      check("start_a_2", 64'(upd_log[2]), 64'd262144);
      check("start_a_3", 64'(upd_log[3]), 64'd393216);
    end
    wait_drain("sector1_drain");

    // Written words vs expected
    check("write_count", 64'(wr_log.size()), 64'(exp_log.size()));
    if (wr_log.size() > 0) check("first_write", 64'(wr_log[0]), {21'd0, 27'd0, 16'h1234});
    for (int k = 0; k < exp_log.size() && k < wr_log.size(); k++)
      check($sformatf("write_%0d", k), 64'(wr_log[k]), 64'(exp_log[k]));
    bad = 0;
    foreach (wr_len[k]) if (wr_len[k] != 2) bad++;
    check("write_lengths", 64'(bad), 64'd0);

    // Playback read vectors
    prev_audio = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      ram_dq_o = rds[i].data;
      playback_a = rds[i].addr;
      @(negedge clk) play = 1'b1;
      @(negedge clk) play = 1'b0;
      check($sformatf("rd%0d_addr", i), 64'(ram_a), 64'(rds[i].addr));
      check($sformatf("rd%0d_strobes", i), 64'({ram_cen, ram_oen, ram_wen}), 64'b001);
      @(negedge clk);
      check($sformatf("rd%0d_latency", i), 64'(audio_out), 64'(prev_audio));
      @(negedge clk);
      check($sformatf("rd%0d_audio", i), 64'(audio_out), 64'(rds[i].exp_audio));
      prev_audio = rds[i].exp_audio;
      repeat (2) @(negedge clk);
    end

    // Reload from SD_DONE; play arriving during a write waits for it
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
    check("reload_state", 64'(dut.sd_i.state), 64'd1);
    check("reload_address", 64'(sd_address), 64'd0);
    wr_log.delete();
    wr_len.delete();
    sd_ready = 1'b1;
    spi_tick();
    sd_ready = 1'b0;
    send_byte(8'h78);
    sd_dout = 8'h56;
    sd_byte_available = 1'b1;
    @(negedge clk) spi_clk = 1'b1;
    for (n = 0; n < 20 && ram_wen; n++) @(negedge clk);
    check("reload_write_seen", 64'(ram_wen), 64'd0);
    play = 1'b1;
    playback_a = 27'd9;
    ram_dq_o = 16'hCAFE;
    @(negedge clk);
    check("write_not_preempted", 64'({ram_wen, ram_oen}), 64'b01);
    for (n = 0; n < 8 && ram_oen; n++) @(negedge clk);
    check("read_after_write", 64'({ram_cen, ram_oen, ram_wen}), 64'b001);
    check("read_after_write_addr", 64'(ram_a), 64'd9);
    check("write_completed", 64'(wr_len.size() == 1 && wr_len[0] == 2), 64'd1);
    if (wr_log.size() > 0) check("reload_write", 64'(wr_log[0]), {21'd0, 27'd0, 16'h5678});
    play = 1'b0;
    repeat (2) @(negedge clk);
    check("read_after_write_audio", 64'(audio_out), 64'hCAFE);

    // Asynchronous reset during a read raises strobes before the next clk edge
    spi_clk = 1'b0;
    sd_byte_available = 1'b0;
    playback_a = 27'd3;
    @(negedge clk) play = 1'b1;
    @(negedge clk) play = 1'b0;
    check("pre_reset_read", 64'(ram_oen), 64'd0);
    #2 reset = 1'b0;
    #1;
    check("async_reset_strobes", 64'({ram_cen, ram_oen, ram_wen}), 64'b111);
    check("async_reset_state", 64'({dut.sd_i.state, audio_out}), 64'd0);
    check("async_reset_fifo", 64'(dut.fifo_req.empty), 64'd1);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
